// File: rtl/key_pkg.sv
// Shared definitions for the key press counter: debounce FSM encoding,
// default timing for a 50 MHz board clock, display digit geometry and the
// BCD increment helper used when KEY_PRESS_COUNTER_BCD_EN is defined.
package key_pkg;

   typedef enum logic [1:0] {
      ST_RELEASED     = 2'd0,
      ST_PRESS_WAIT   = 2'd1,
      ST_PRESSED      = 2'd2,
      ST_RELEASE_WAIT = 2'd3
   } key_state_e;

   // 20 ms of stability at 50 MHz
   localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;
   localparam int NIBBLE_W                = 4;
   localparam int NUM_DIGITS              = 4;
   localparam logic [NIBBLE_W-1:0] BCD_MAX = 4'd9;

   // Increment a four-digit packed BCD value with ripple carry; a digit at
   // (or above) 9 rolls to 0 and carries, so 9999 wraps to 0000.
   function automatic logic [NUM_DIGITS*NIBBLE_W-1:0] bcd_inc(
      input logic [NUM_DIGITS*NIBBLE_W-1:0] value
   );
      logic [NUM_DIGITS*NIBBLE_W-1:0] result;
      logic                           carry;
      result = value;
      carry  = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (carry) begin
            if (value[i*NIBBLE_W +: NIBBLE_W] >= BCD_MAX) begin
               result[i*NIBBLE_W +: NIBBLE_W] = 4'd0;
               carry = 1'b1;
            end else begin
               result[i*NIBBLE_W +: NIBBLE_W] = value[i*NIBBLE_W +: NIBBLE_W] + 4'd1;
               carry = 1'b0;
            end
         end else begin
            result[i*NIBBLE_W +: NIBBLE_W] = value[i*NIBBLE_W +: NIBBLE_W];
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/key_debounce.sv
// Push-button debouncer: two-flop synchronizer on the raw active-low key,
// then a four-state FSM that accepts a new level only after it has been seen
// for DEBOUNCE_CYCLES consecutive clocks. Emits the debounced level and a
// one-clock strobe on each accepted release-to-press transition.
module key_debounce
   import key_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int CNT_W           = 24
) (
   input  logic i_clk,
   input  logic i_reset_n,
   input  logic i_key_n,
   output logic o_pressed,
   output logic o_press_pulse
);

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_r;
   logic             sync2_r;
   logic             key_s;
   key_state_e       state_r;
   logic [CNT_W-1:0] cnt_r;
   logic             pressed_r;
   logic             pulse_r;

   // Two-stage synchronizer; idles high (released) out of reset
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         sync1_r <= 1'b1;
         sync2_r <= 1'b1;
      end else begin
         sync1_r <= i_key_n;
         sync2_r <= sync1_r;
      end
   end

   assign key_s = sync2_r;

   // Debounce FSM with stability counter; level and strobe are registered here
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_r   <= ST_RELEASED;
         cnt_r     <= CNT_ZERO;
         pressed_r <= 1'b0;
         pulse_r   <= 1'b0;
      end else begin
         pulse_r <= 1'b0;
         case (state_r)
            ST_RELEASED: begin
               if (!key_s) begin
                  state_r <= ST_PRESS_WAIT;
                  cnt_r   <= CNT_ONE;
               end else begin
                  cnt_r   <= CNT_ZERO;
               end
            end
            ST_PRESS_WAIT: begin
               if (key_s) begin
                  state_r <= ST_RELEASED;
                  cnt_r   <= CNT_ZERO;
               end else if (cnt_r == CNT_LAST) begin
                  state_r   <= ST_PRESSED;
                  cnt_r     <= CNT_ZERO;
                  pressed_r <= 1'b1;
                  pulse_r   <= 1'b1;
               end else begin
                  cnt_r <= cnt_r + CNT_ONE;
               end
            end
            ST_PRESSED: begin
               if (key_s) begin
                  state_r <= ST_RELEASE_WAIT;
                  cnt_r   <= CNT_ONE;
               end else begin
                  cnt_r   <= CNT_ZERO;
               end
            end
            ST_RELEASE_WAIT: begin
               if (!key_s) begin
                  state_r <= ST_PRESSED;
                  cnt_r   <= CNT_ZERO;
               end else if (cnt_r == CNT_LAST) begin
                  state_r   <= ST_RELEASED;
                  cnt_r     <= CNT_ZERO;
                  pressed_r <= 1'b0;
               end else begin
                  cnt_r <= cnt_r + CNT_ONE;
               end
            end
            default: begin
               state_r   <= ST_RELEASED;
               cnt_r     <= CNT_ZERO;
               pressed_r <= 1'b0;
            end
         endcase
      end
   end

   assign o_pressed     = pressed_r;
   assign o_press_pulse = pulse_r;

endmodule

// File: rtl/key_press_counter.sv
// Key press counter: debounces one active-low button and counts accepted
// presses in a 16-bit register shown as four nibbles for 7-segment decoders.
// Build option KEY_PRESS_COUNTER_BCD_EN switches the count to four BCD digits
// (0000..9999); by default it is plain binary (0000..FFFF, hex display).
module key_press_counter
   import key_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int CNT_W           = 24
) (
   input  logic                i_clk,
   input  logic                i_reset_n,
   input  logic                i_key_n,
   input  logic                i_clear,
   output logic                o_pressed,
   output logic                o_press_pulse,
   output logic [NIBBLE_W-1:0] o_val0,
   output logic [NIBBLE_W-1:0] o_val1,
   output logic [NIBBLE_W-1:0] o_val2,
   output logic [NIBBLE_W-1:0] o_val3
);

   localparam int COUNT_W = NUM_DIGITS * NIBBLE_W;

   logic               pulse_s;
   logic [COUNT_W-1:0] count_r;
   logic [COUNT_W-1:0] count_inc_s;

   key_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_debounce (
      .i_clk         (i_clk),
      .i_reset_n     (i_reset_n),
      .i_key_n       (i_key_n),
      .o_pressed     (o_pressed),
      .o_press_pulse (pulse_s)
   );

   assign o_press_pulse = pulse_s;

`ifdef KEY_PRESS_COUNTER_BCD_EN
   assign count_inc_s = bcd_inc(count_r);
`else
   assign count_inc_s = count_r + 16'd1;
`endif

   // Press counter; clear beats a coincident press, wrap is silent
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         count_r <= 16'd0;
      end else if (i_clear) begin
         count_r <= 16'd0;
      end else if (pulse_s) begin
         count_r <= count_inc_s;
      end else begin
         count_r <= count_r;
      end
   end

   assign o_val0 = count_r[0*NIBBLE_W +: NIBBLE_W];
   assign o_val1 = count_r[1*NIBBLE_W +: NIBBLE_W];
   assign o_val2 = count_r[2*NIBBLE_W +: NIBBLE_W];
   assign o_val3 = count_r[3*NIBBLE_W +: NIBBLE_W];

endmodule

// File: tb/tb_key_press_counter.sv
// Self-checking bench for key_press_counter with DEBOUNCE_CYCLES=4.
// A reference model tracks the key as a 2-clock delayed sample stream and
// flips the debounced level once DEBOUNCE_CYCLES consecutive samples disagree
// with it; the count is kept as a plain integer modulo 65536 (or 10000 for the
// KEY_PRESS_COUNTER_BCD_EN build) and converted to display digits.
module tb_key_press_counter;

   localparam int D = 4;
`ifdef KEY_PRESS_COUNTER_BCD_EN
   localparam int MOD      = 10000;
   localparam int WRAP_TOP = 9999;
   localparam int CLR_PRE  = 12;
`else
   localparam int MOD      = 65536;
   localparam int WRAP_TOP = 65535;
   localparam int CLR_PRE  = 18;
`endif

   logic       i_clk = 1'b0;
   logic       i_reset_n;
   logic       i_key_n;
   logic       i_clear;
   logic       o_pressed;
   logic       o_press_pulse;
   logic [3:0] o_val0, o_val1, o_val2, o_val3;

   int n_assert = 0;
   int n_fail   = 0;

   // reference model state
   logic [1:0] dly_m;
   int         run_m;
   logic       level_m;
   logic       pulse_m;
   int         cnt_m;

   logic [15:0] preload_v;

   key_press_counter #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
      .i_clk         (i_clk),
      .i_reset_n     (i_reset_n),
      .i_key_n       (i_key_n),
      .i_clear       (i_clear),
      .o_pressed     (o_pressed),
      .o_press_pulse (o_press_pulse),
      .o_val0        (o_val0),
      .o_val1        (o_val1),
      .o_val2        (o_val2),
      .o_val3        (o_val3)
   );

   always #5 i_clk = ~i_clk;

   function automatic logic [15:0] to_disp(input int v);
`ifdef KEY_PRESS_COUNTER_BCD_EN
      return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
`else
      return 16'(v);
`endif
   endfunction

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      dly_m   = 2'b11;
      run_m   = 0;
      level_m = 1'b0;
      pulse_m = 1'b0;
      cnt_m   = 0;
   endtask

   task automatic model_step(input logic key, input logic clr);
      logic ks;
      if (clr) cnt_m = 0;
      else if (pulse_m) cnt_m = (cnt_m + 1) % MOD;
      ks       = dly_m[1];
      dly_m    = {dly_m[0], key};
      pulse_m  = 1'b0;
      // a sample disagrees with the level when key_n equals the pressed flag
      if (ks == level_m) begin
         run_m++;
         if (run_m == D) begin
            level_m = ~level_m;
            run_m   = 0;
            pulse_m = level_m;
         end
      end else begin
         run_m = 0;
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, "_pressed"}, {15'd0, o_pressed}, {15'd0, level_m});
      check({tag, "_pulse"}, {15'd0, o_press_pulse}, {15'd0, pulse_m});
      check({tag, "_count"}, {o_val3, o_val2, o_val1, o_val0}, to_disp(cnt_m));
   endtask

   // drive at negedge, clock one edge, advance model, check at next negedge
   task automatic tick(input logic key, input logic clr, input string tag);
      i_key_n = key;
      i_clear = clr;
      @(posedge i_clk);
      model_step(key, clr);
      @(negedge i_clk);
      check_all(tag);
   endtask

   task automatic ticks(input int n, input logic key, input string tag);
      for (int i = 0; i < n; i++) tick(key, 1'b0, tag);
   endtask

   task automatic preload(input int pre);
      preload_v = to_disp(pre);
      force dut.count_r = preload_v;
      i_key_n = 1'b1;
      i_clear = 1'b0;
      @(posedge i_clk);
      model_step(1'b1, 1'b0);
      cnt_m = pre;
      @(negedge i_clk);
      release dut.count_r;
      check_all("preload");
   endtask

   task automatic pulse_reset();
      i_reset_n = 1'b0;
      #1;
      check("rst_imm_pressed", {15'd0, o_pressed}, 16'd0);
      check("rst_imm_pulse", {15'd0, o_press_pulse}, 16'd0);
      check("rst_imm_count", {o_val3, o_val2, o_val1, o_val0}, 16'd0);
      model_reset();
      @(posedge i_clk);
      @(negedge i_clk);
      i_reset_n = 1'b1;
   endtask

   initial begin
      int len;
      logic val;

      // power-on reset
      i_reset_n = 1'b0;
      i_key_n   = 1'b1;
      i_clear   = 1'b0;
      model_reset();
      repeat (2) @(negedge i_clk);
      check("por_pressed", {15'd0, o_pressed}, 16'd0);
      check("por_pulse", {15'd0, o_press_pulse}, 16'd0);
      check("por_count", {o_val3, o_val2, o_val1, o_val0}, 16'd0);
      i_reset_n = 1'b1;
      ticks(5, 1'b1, "idle");

      // bounce shorter than the debounce window: nothing accepted
      for (int r = 0; r < 5; r++) begin
         ticks(3, 1'b0, "bounce_lo");
         ticks(3, 1'b1, "bounce_hi");
      end
      check("bounce_pressed", {15'd0, o_pressed}, 16'd0);
      check("bounce_count", {o_val3, o_val2, o_val1, o_val0}, 16'd0);

      // clean press: pulse on the 6th edge counting the first sampling edge
      for (int i = 1; i <= 10; i++) begin
         tick(1'b0, 1'b0, "clean");
         check("clean_pulse_edge", {15'd0, o_press_pulse}, (i == 6) ? 16'd1 : 16'd0);
      end
      check("clean_pressed", {15'd0, o_pressed}, 16'd1);
      check("clean_count", {o_val3, o_val2, o_val1, o_val0}, 16'd1);

      // short release glitch while pressed: level holds, no second pulse
      for (int i = 0; i < 10; i++) begin
         tick((i < 2) ? 1'b1 : 1'b0, 1'b0, "rel_glitch");
         check("glitch_held", {15'd0, o_pressed}, 16'd1);
         check("glitch_nopulse", {15'd0, o_press_pulse}, 16'd0);
      end
      ticks(10, 1'b1, "release");
      check("release_level", {15'd0, o_pressed}, 16'd0);

      // wrap at the top of the count range
      preload(WRAP_TOP);
      ticks(10, 1'b0, "wrap_press");
      ticks(10, 1'b1, "wrap_rel");
      check("wrap_zero", {o_val3, o_val2, o_val1, o_val0}, 16'd0);

      // digit carry (0x0009 -> 0x000A in hex, 0009 -> 0010 in BCD)
      preload(9);
      ticks(10, 1'b0, "carry_press");
      ticks(10, 1'b1, "carry_rel");
`ifdef KEY_PRESS_COUNTER_BCD_EN
      check("carry_digit", {o_val3, o_val2, o_val1, o_val0}, 16'h0010);
`else
      check("carry_digit", {o_val3, o_val2, o_val1, o_val0}, 16'h000A);
`endif

      // clear coincident with the press strobe wins
      preload(CLR_PRE);
      check("clr_pre_0012", {o_val3, o_val2, o_val1, o_val0}, 16'h0012);
      len = 0;
      i_key_n = 1'b0;
      while (!pulse_m && len < 20) begin
         tick(1'b0, 1'b0, "clr_press");
         len++;
      end
      check("clr_pulse_seen", {15'd0, o_press_pulse}, 16'd1);
      tick(1'b0, 1'b1, "clr_same");
      check("clr_priority", {o_val3, o_val2, o_val1, o_val0}, 16'd0);
      ticks(10, 1'b1, "clr_rel");

      // clear on its own
      preload(5);
      tick(1'b1, 1'b1, "clr_alone");
      check("clr_alone_zero", {o_val3, o_val2, o_val1, o_val0}, 16'd0);

      // reset with key released: outputs stay at zero
      pulse_reset();
      ticks(8, 1'b1, "rst_idle");

      // mid-debounce reset with key held, then held through release
      ticks(2, 1'b0, "mid_deb");
      pulse_reset();
      for (int i = 1; i <= 10; i++) begin
         tick(1'b0, 1'b0, "held_rst");
         check("held_pulse_edge", {15'd0, o_press_pulse}, (i == 6) ? 16'd1 : 16'd0);
      end
      check("held_count", {o_val3, o_val2, o_val1, o_val0}, 16'd1);
      ticks(10, 1'b1, "held_rel");

      // randomized key runs with occasional clears
      for (int k = 0; k < 60; k++) begin
         len = int'($urandom_range(1, 8));
         val = 1'($urandom_range(0, 1));
         for (int j = 0; j < len; j++) begin
            tick(val, ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0, "rand");
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/key_press_counter.md
Name: key_press_counter

Overview:
- Debounces one raw active-low push-button and counts debounced presses in a 16-bit counter.
- Presents the count as four 4-bit nibbles, each feeding one static 7-segment decoder (digits 0..3) on the DE2-115 debouncer test design.
- Also exports the debounced level and a one-cycle press strobe for LEDs and other logic.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable clocks required to accept a new level (20 ms at 50 MHz); legal range 2..2^24-1.
- CNT_W, 24, width of the stability counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- i_clk  input  1  system clock (50 MHz on board).
- i_reset_n  input  1  asynchronous active-low reset.
- i_key_n  input  1  raw button, asynchronous to i_clk, 0 = pressed.
- i_clear  input  1  synchronous clear of the press count.
- o_pressed  output  1  debounced level, 1 = pressed.
- o_press_pulse  output  1  one-clock strobe on an accepted release-to-press transition.
- o_val0  output  4  count[3:0], least significant digit.
- o_val1  output  4  count[7:4].
- o_val2  output  4  count[11:8].
- o_val3  output  4  count[15:12].

Behaviour:
- Clocking and reset: one clock, i_clk. i_reset_n is asynchronous and active-low; assertion takes effect immediately and release is sampled on i_clk.
- Reset values:
  - synchronizer flops = 1 (released)
  - stability counter = 0
  - FSM = RELEASED
  - o_pressed = 0, o_press_pulse = 0
  - count = 0, so o_val0..3 = 0
- Synchronizer: two flops on i_key_n; only the second flop output (key_s) is used downstream.
- FSM states: RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT.
  - RELEASED: key_s=0 -> PRESS_WAIT, counter=1.
  - PRESS_WAIT:
    - key_s=1 -> RELEASED, counter=0 (glitch rejected).
    - key_s=0 and counter==DEBOUNCE_CYCLES-1 -> PRESSED, counter=0, o_press_pulse=1 for this single clock.
    - otherwise counter++.
  - PRESSED: key_s=1 -> RELEASE_WAIT, counter=1.
  - RELEASE_WAIT: mirror of PRESS_WAIT. key_s=0 -> PRESSED. Stable for the full count -> RELEASED, with no pulse.
- o_pressed: registered; 1 in PRESSED and RELEASE_WAIT, 0 otherwise.
- Latency:
  - Raw edge held stable -> o_press_pulse high exactly DEBOUNCE_CYCLES+2 rising edges after the first edge sampling the new level.
  - count updates on the edge following the pulse.
- Count rules:
  - +1 per o_press_pulse.
  - Wraps 0xFFFF -> 0x0000 with no flag.
  - i_clear sets count=0 on the next edge.
  - i_clear and pulse in the same cycle: clear wins, count=0 (the press is not counted).
- Bounce shorter than DEBOUNCE_CYCLES in either direction produces no level change and no pulse.
- Reset mid-debounce discards the partial count. After release the FSM restarts in RELEASED, even if the key is held, so a held key produces one pulse DEBOUNCE_CYCLES+2 clocks after reset release.
- o_val outputs are registered, glitch-free, and directly drive the 7-segment decoders.

Optional Feature:
- Macro: KEY_PRESS_COUNTER_BCD_EN.
- Defined: count is four BCD digits, each 0..9.
  - A digit at 9 increments to 0 and carries into the next digit.
  - 9999 + 1 -> 0000.
  - i_clear and priority rules are unchanged.
- Undefined: plain 16-bit binary (hex display) as described above.

Decomposition:
- Shared package key_pkg:
  - FSM state encoding constants (2 bits).
  - Default DEBOUNCE_CYCLES for 50 MHz.
  - Nibble width constant 4.
  - BCD digit maximum 9.
- Sub-module key_debounce: synchronizer + FSM + stability counter, with outputs o_pressed and o_press_pulse.
- Top level instantiates key_debounce and holds the counter, including the BCD variant.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset: assert i_reset_n=0 mid-run -> all outputs 0 immediately; after release with key released, outputs stay 0.
- Clean press: i_key_n 1->0 held 10 clocks -> o_press_pulse high exactly 6 edges after the first sampling edge, for 1 clock; o_pressed=1; o_val0=1 next edge.
- Bounce: i_key_n low for 3 clocks then high, repeated 5 times -> no pulse, o_pressed=0, count stays 0. Then a 2-clock release glitch while pressed -> o_pressed stays 1 and no second pulse.
- Wrap: 0xFFFF presses, forced via a back-door count preload -> next press gives o_val3..0 = 0,0,0,0. BCD build: 9999 -> 0000, and 0009 -> 0010.
- Clear priority: i_clear asserted in the same cycle as o_press_pulse with count=0x0012 -> count=0x0000. i_clear alone -> count=0 on the next edge.
- Held through reset: key held low, reset pulsed -> exactly one pulse 6 clocks after release, count=1.
